// File: rtl/mult_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit holding the architectural HI/LO registers.
// Optional macro MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier is zero.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   rs_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   divisor;

  logic signed [WIDTH-1:0] rs_sv;
  logic signed [WIDTH-1:0] rt_sv;
  logic                    op_signed;
  logic                    rs_neg;
  logic                    rt_neg;
  logic                    accept;
  logic                    calc_last;
  logic [2*WIDTH-1:0]      prod_nxt;
  logic [WIDTH-1:0]        mplier_nxt;
  logic [WIDTH:0]          div_shift;
  logic [WIDTH:0]          div_trial;
  logic [WIDTH-1:0]        rem_nxt;
  logic [WIDTH-1:0]        quo_nxt;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? ({(2*WIDTH){1'b0}} - v) : v;
  endfunction

  assign rs_sv     = rs_data;
  assign rt_sv     = rt_data;
  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & (rs_sv < 0);
  assign rt_neg    = op_signed & (rt_sv < 0);
  assign accept    = start & ((state == S_IDLE) | (state == S_DONE));

  // Multiply step: add the left-shifting multiplicand when the multiplier LSB is set.
  assign prod_nxt   = mplier[0] ? (prod + mcand) : prod;
  assign mplier_nxt = mplier >> 1;

  // Restoring divide step: shift in the next dividend bit, keep the difference if non-negative.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, divisor};
  assign rem_nxt   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~div_trial[WIDTH]};

`ifdef MDU_EARLY_TERM_EN
  assign calc_last = (cnt == CNT_W'(WIDTH - 1)) | (~is_div_q & (mplier_nxt == '0));
`else
  assign calc_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      rs_q     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (accept) begin
            state    <= S_CALC;
            busy     <= 1'b1;
            cnt      <= '0;
            is_div_q <= op[1];
            sign_a   <= rs_neg;
            sign_b   <= rt_neg;
            rs_q     <= rs_data;
            mcand    <= {{WIDTH{1'b0}}, cond_neg(rs_data, rs_neg)};
            mplier   <= cond_neg(rt_data, rt_neg);
            prod     <= '0;
            rem      <= '0;
            quo      <= cond_neg(rs_data, rs_neg);
            divisor  <= cond_neg(rt_data, rt_neg);
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div_q) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
          end
          if (calc_last) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div_q) begin
            {hi, lo} <= cond_neg2(prod, sign_a ^ sign_b);
          end else if (divisor == '0) begin
            hi <= rs_q;
            lo <= '1;
          end else begin
            lo <= cond_neg(quo, sign_a ^ sign_b);
            hi <= cond_neg(rem, sign_a);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
